// File: rtl/fmap_stream_reader.sv
// Raster-order feature-map reader: issues one memory read per pixel and streams
// the returned pixels through a 2-entry output FIFO with ready/valid handshake.
module fmap_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            img_width,
    input  logic [7:0]            img_height,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_width;
    logic [7:0]              r_height;
    logic [7:0]              r_row;
    logic [7:0]              r_col;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_rd_pend;
    logic                    r_rd_pend_last;
    logic [DATA_WIDTH-1:0]   r_fifo_data [2];
    logic                    r_fifo_last [2];
    logic                    r_wptr;
    logic                    r_rptr;
    logic [1:0]              r_count;
    logic                    r_done;

    logic                    w_pop;
    logic                    w_last_rd;
    logic                    w_rd_en;

    assign valid_out = (r_count != 2'd0);
    assign data_out  = r_fifo_data[r_rptr];
    assign last_out  = valid_out && r_fifo_last[r_rptr];
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign mem_rd_en = w_rd_en;
    assign mem_addr  = r_addr;

    assign w_pop     = valid_out && ready_in;
    assign w_last_rd = (r_col == (r_width - 8'd1)) && (r_row == (r_height - 8'd1));

    // Read gate: a read issued now lands in the FIFO one cycle later, so the
    // FIFO plus the read already returning, less this cycle's pop, must leave a slot.
    always_comb begin
        w_rd_en = 1'b0;
        if (r_state == ST_RUN) begin
            if (({1'b0, r_count} + {2'b00, r_rd_pend} - {2'b00, w_pop}) < 3'd2) begin
                w_rd_en = 1'b1;
            end else begin
                w_rd_en = 1'b0;
            end
        end else begin
            w_rd_en = 1'b0;
        end
    end

    // Frame FSM, raster counters, read pipeline and output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_width        <= 8'd0;
            r_height       <= 8'd0;
            r_row          <= 8'd0;
            r_col          <= 8'd0;
            r_addr         <= {ADDR_WIDTH{1'b0}};
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            r_fifo_data[0] <= {DATA_WIDTH{1'b0}};
            r_fifo_data[1] <= {DATA_WIDTH{1'b0}};
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= 2'd0;
            r_done         <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_rd_pend      <= w_rd_en;
            r_rd_pend_last <= w_rd_en && w_last_rd;

            if (r_rd_pend) begin
                r_fifo_data[r_wptr] <= mem_rd_data;
                r_fifo_last[r_wptr] <= r_rd_pend_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_rd_pend} - {1'b0, w_pop};

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if ((img_width != 8'd0) && (img_height != 8'd0)) begin
                            r_width  <= img_width;
                            r_height <= img_height;
                            r_row    <= 8'd0;
                            r_col    <= 8'd0;
                            r_addr   <= base_addr;
                            r_state  <= ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_rd_en) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (r_col == (r_width - 8'd1)) begin
                            r_col <= 8'd0;
                            r_row <= r_row + 8'd1;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                        if (w_last_rd) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && last_out) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
